// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller: RV32 opcodes, forwarding
// select encodings, FSM states and the source-register usage decode.
package hazard_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LSTALL = 2'b01,
    ST_MWAIT  = 2'b10
  } hz_state_e;

  // Returns {uses_rs2, uses_rs1}; unknown opcodes use neither.
  function automatic logic [1:0] src_usage(input logic [6:0] op);
    logic [1:0] u;
    u = 2'b00;
    case (op)
      OP_R, OP_STORE, OP_BRANCH: u = 2'b11;
      OP_I, OP_LOAD, OP_JALR:    u = 2'b01;
      default:                   u = 2'b00;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The pipeline side is the
// master modport, the controller the slave.
interface hazard_ctrl_if #(
  parameter int N     = 32,
  parameter int REG_W = 5
);
  logic [N-1:0]     id_instr;
  logic             idex_memread;
  logic [REG_W-1:0] idex_rd;
  logic [REG_W-1:0] idex_rs1;
  logic [REG_W-1:0] idex_rs2;
  logic [REG_W-1:0] exmem_rd;
  logic             exmem_regwrite;
  logic [REG_W-1:0] memwb_rd;
  logic             memwb_regwrite;
  logic             branch_taken;
  logic             mem_busy;
  logic             pc_write;
  logic             ifid_write;
  logic             pipe_hold;
  logic             ctrl_select;
  logic             ifid_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  modport master (
    output id_instr, idex_memread, idex_rd, idex_rs1, idex_rs2,
           exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite,
           branch_taken, mem_busy,
    input  pc_write, ifid_write, pipe_hold, ctrl_select, ifid_flush,
           fwd_a, fwd_b
  );

  modport slave (
    input  id_instr, idex_memread, idex_rd, idex_rs1, idex_rs2,
           exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite,
           branch_taken, mem_busy,
    output pc_write, ifid_write, pipe_hold, ctrl_select, ifid_flush,
           fwd_a, fwd_b
  );
endinterface

// File: rtl/hazard_ctrl_fwd.sv
// EX-stage forwarding select for one source operand; EX/MEM beats MEM/WB.
module fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] i_src,
  input  logic [REG_W-1:0] i_exmem_rd,
  input  logic             i_exmem_regwrite,
  input  logic [REG_W-1:0] i_memwb_rd,
  input  logic             i_memwb_regwrite,
  output fwd_sel_e         o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (i_exmem_regwrite && (i_exmem_rd != '0) && (i_exmem_rd == i_src))
      o_sel = FWD_MEM;
    else if (i_memwb_regwrite && (i_memwb_rd != '0) && (i_memwb_rd == i_src))
      o_sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / branch-flush / memory-freeze controller with EX forwarding.
// Optional HAZARD_STATS_EN adds stall_cycles and flush_count outputs.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int N        = 32,
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]  stall_cycles,
  output logic [31:0]  flush_count
`endif
);

  localparam int CNT_W = 3;

  if (N < 25 || REG_W != 5) begin : g_param_chk
    $error("hazard_ctrl: N must hold an RV32 instruction and REG_W must be 5");
  end
  if (LOAD_LAT < 1 || LOAD_LAT > 7) begin : g_lat_chk
    $error("hazard_ctrl: LOAD_LAT must be 1..7");
  end

  hz_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic [6:0]       w_opcode;
  logic [REG_W-1:0] w_rs1, w_rs2;
  logic [1:0]       w_use;
  logic             w_hazard;
  logic             w_idle_eval;
  logic             w_pc, w_ifid, w_hold, w_ctrl, w_flush;
  fwd_sel_e         w_fwd_a, w_fwd_b;

  assign w_opcode = bus.id_instr[6:0];
  assign w_rs1    = bus.id_instr[19:15];
  assign w_rs2    = bus.id_instr[24:20];
  assign w_use    = src_usage(w_opcode);
  assign w_hazard = bus.idex_memread && (bus.idex_rd != '0) &&
                    ((w_use[0] && (bus.idex_rd == w_rs1)) ||
                     (w_use[1] && (bus.idex_rd == w_rs2)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // MWAIT's release cycle falls through to the IDLE decision so a
  // lingering load-use hazard stalls without a lost cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pc        = 1'b1;
    w_ifid      = 1'b1;
    w_hold      = 1'b0;
    w_ctrl      = 1'b1;
    w_flush     = 1'b0;
    w_idle_eval = 1'b0;

    case (r_state)
      ST_IDLE: w_idle_eval = 1'b1;
      ST_LSTALL: begin
        if (bus.mem_busy) begin
          w_pc = 1'b0; w_ifid = 1'b0; w_hold = 1'b1;
          w_state_nxt = ST_MWAIT;
          w_cnt_nxt   = '0;
        end else if (bus.branch_taken) begin
          w_flush = 1'b1; w_ctrl = 1'b0;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_pc = 1'b0; w_ifid = 1'b0; w_ctrl = 1'b0;
          if (r_cnt <= CNT_W'(1)) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
      end
      ST_MWAIT: begin
        if (bus.mem_busy) begin
          w_pc = 1'b0; w_ifid = 1'b0; w_hold = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_idle_eval = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    if (w_idle_eval) begin
      if (bus.mem_busy) begin
        w_pc = 1'b0; w_ifid = 1'b0; w_hold = 1'b1;
        w_state_nxt = ST_MWAIT;
      end else if (bus.branch_taken) begin
        w_flush = 1'b1; w_ctrl = 1'b0;
      end else if (w_hazard) begin
        w_pc = 1'b0; w_ifid = 1'b0; w_ctrl = 1'b0;
        w_cnt_nxt   = CNT_W'(LOAD_LAT - 1);
        w_state_nxt = (LOAD_LAT > 1) ? ST_LSTALL : ST_IDLE;
      end
    end

    if (!rst_n) begin
      w_pc = 1'b1; w_ifid = 1'b1; w_hold = 1'b0; w_ctrl = 1'b1; w_flush = 1'b0;
    end
  end

  fwd_unit #(.REG_W(REG_W)) u_fwd_a (
    .i_src            (bus.idex_rs1),
    .i_exmem_rd       (bus.exmem_rd),
    .i_exmem_regwrite (bus.exmem_regwrite),
    .i_memwb_rd       (bus.memwb_rd),
    .i_memwb_regwrite (bus.memwb_regwrite),
    .o_sel            (w_fwd_a)
  );

  fwd_unit #(.REG_W(REG_W)) u_fwd_b (
    .i_src            (bus.idex_rs2),
    .i_exmem_rd       (bus.exmem_rd),
    .i_exmem_regwrite (bus.exmem_regwrite),
    .i_memwb_rd       (bus.memwb_rd),
    .i_memwb_regwrite (bus.memwb_regwrite),
    .o_sel            (w_fwd_b)
  );

  assign bus.pc_write    = w_pc;
  assign bus.ifid_write  = w_ifid;
  assign bus.pipe_hold   = w_hold;
  assign bus.ctrl_select = w_ctrl;
  assign bus.ifid_flush  = w_flush;
  assign bus.fwd_a       = rst_n ? w_fwd_a : FWD_RF;
  assign bus.fwd_b       = rst_n ? w_fwd_b : FWD_RF;

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cycles, r_flush_count;
  logic        w_stall_evt;

  assign w_stall_evt = (r_state == ST_LSTALL) || (r_state == ST_MWAIT) ||
                       ((r_state == ST_IDLE) && !bus.mem_busy &&
                        !bus.branch_taken && w_hazard);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_flush && (r_flush_count != '1))
        r_flush_count <= r_flush_count + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (LOAD_LAT=1 and 3) share
// stimulus; a vector table covers single-cycle decode, sequences cover the FSM.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  typedef struct packed {
    logic [31:0] instr;
    logic        memread;
    logic [4:0]  idex_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  exmem_rd;
    logic        exmem_rw;
    logic [4:0]  memwb_rd;
    logic        memwb_rw;
    logic        branch;
    logic        busy;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [4:0] ctl;
    logic [1:0] fa;
    logic [1:0] fb;
  } vec_t;

  // {pc_write, ifid_write, pipe_hold, ctrl_select, ifid_flush}
  localparam logic [4:0] CTL_RUN    = 5'b11010;
  localparam logic [4:0] CTL_STALL  = 5'b00000;
  localparam logic [4:0] CTL_FREEZE = 5'b00110;
  localparam logic [4:0] CTL_FLUSH  = 5'b11001;

  localparam logic [31:0] I_ADD_RS1  = 32'h00728333; // add x6,x5,x7
  localparam logic [31:0] I_NOP      = 32'h00000013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.N(32), .REG_W(5)) if1 ();
  hazard_ctrl_if #(.N(32), .REG_W(5)) if3 ();

`ifdef HAZARD_STATS_EN
  logic [31:0] sc1, fc1, sc3, fc3;
`endif

  hazard_ctrl #(.N(32), .REG_W(5), .LOAD_LAT(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
`ifdef HAZARD_STATS_EN
    , .stall_cycles (sc1), .flush_count (fc1)
`endif
  );

  hazard_ctrl #(.N(32), .REG_W(5), .LOAD_LAT(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if3)
`ifdef HAZARD_STATS_EN
    , .stall_cycles (sc3), .flush_count (fc3)
`endif
  );

  logic [4:0] ctl1, ctl3;
  assign ctl1 = {if1.pc_write, if1.ifid_write, if1.pipe_hold, if1.ctrl_select, if1.ifid_flush};
  assign ctl3 = {if3.pc_write, if3.ifid_write, if3.pipe_hold, if3.ctrl_select, if3.ifid_flush};

  function automatic in_t mk(input logic [31:0] instr, input logic mr, input logic [4:0] rd,
                             input logic [4:0] s1, input logic [4:0] s2,
                             input logic [4:0] exrd, input logic exrw,
                             input logic [4:0] wbrd, input logic wbrw,
                             input logic br, input logic busy);
    in_t v;
    v.instr = instr; v.memread = mr; v.idex_rd = rd; v.rs1 = s1; v.rs2 = s2;
    v.exmem_rd = exrd; v.exmem_rw = exrw; v.memwb_rd = wbrd; v.memwb_rw = wbrw;
    v.branch = br; v.busy = busy;
    return v;
  endfunction

  task automatic apply(input in_t v);
    if1.id_instr = v.instr;       if3.id_instr = v.instr;
    if1.idex_memread = v.memread; if3.idex_memread = v.memread;
    if1.idex_rd = v.idex_rd;      if3.idex_rd = v.idex_rd;
    if1.idex_rs1 = v.rs1;         if3.idex_rs1 = v.rs1;
    if1.idex_rs2 = v.rs2;         if3.idex_rs2 = v.rs2;
    if1.exmem_rd = v.exmem_rd;    if3.exmem_rd = v.exmem_rd;
    if1.exmem_regwrite = v.exmem_rw; if3.exmem_regwrite = v.exmem_rw;
    if1.memwb_rd = v.memwb_rd;    if3.memwb_rd = v.memwb_rd;
    if1.memwb_regwrite = v.memwb_rw; if3.memwb_regwrite = v.memwb_rw;
    if1.branch_taken = v.branch;  if3.branch_taken = v.branch;
    if1.mem_busy = v.busy;        if3.mem_busy = v.busy;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  vec_t tbl[19];
  in_t  neutral, hz, bubble, t;

  initial begin
    neutral = mk(I_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    hz      = mk(I_ADD_RS1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    bubble  = mk(I_ADD_RS1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    tbl[0]  = '{"lw_add_rs1",   hz, CTL_STALL, 2'b00, 2'b00};
    tbl[1]  = '{"lw_add_rs2",   mk(32'h00538333, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0), CTL_STALL, 2'b00, 2'b00};
    tbl[2]  = '{"lui_nostall",  mk(32'h000002B7, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0), CTL_RUN, 2'b00, 2'b00};
    tbl[3]  = '{"addi_imm5",    mk(32'h00548313, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0), CTL_RUN, 2'b00, 2'b00};
    tbl[4]  = '{"sw_rs2",       mk(32'h00538023, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0), CTL_STALL, 2'b00, 2'b00};
    tbl[5]  = '{"lw_rs1",       mk(32'h0002B303, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0), CTL_STALL, 2'b00, 2'b00};
    tbl[6]  = '{"jal_nostall",  mk(32'h000280EF, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0), CTL_RUN, 2'b00, 2'b00};
    tbl[7]  = '{"rd0_nostall",  mk(32'h00700333, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), CTL_RUN, 2'b00, 2'b00};
    tbl[8]  = '{"noload",       mk(I_ADD_RS1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0), CTL_RUN, 2'b00, 2'b00};
    tbl[9]  = '{"branch_hz",    mk(I_ADD_RS1, 1, 5, 0, 0, 0, 0, 0, 0, 1, 0), CTL_FLUSH, 2'b00, 2'b00};
    tbl[10] = '{"busy_prio",    mk(I_ADD_RS1, 1, 5, 0, 0, 0, 0, 0, 0, 1, 1), CTL_FREEZE, 2'b00, 2'b00};
    tbl[11] = '{"fwd_mem",      mk(I_NOP, 0, 0, 8, 3, 8, 1, 8, 1, 0, 0), CTL_RUN, 2'b10, 2'b00};
    tbl[12] = '{"fwd_wb",       mk(I_NOP, 0, 0, 8, 3, 8, 0, 8, 1, 0, 0), CTL_RUN, 2'b01, 2'b00};
    tbl[13] = '{"fwd_split",    mk(I_NOP, 0, 0, 8, 9, 8, 1, 9, 1, 0, 0), CTL_RUN, 2'b10, 2'b01};
    tbl[14] = '{"fwd_x0",       mk(I_NOP, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0), CTL_RUN, 2'b00, 2'b00};
    tbl[15] = '{"fwd_both",     mk(I_NOP, 0, 0, 4, 4, 4, 1, 4, 1, 0, 0), CTL_RUN, 2'b10, 2'b10};
    tbl[16] = '{"beq_rs2",      mk(32'h00628063, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0), CTL_STALL, 2'b00, 2'b00};
    tbl[17] = '{"jalr_rs1",     mk(32'h000280E7, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0), CTL_STALL, 2'b00, 2'b00};
    tbl[18] = '{"auipc_nostall",mk(32'h00028297, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0), CTL_RUN, 2'b00, 2'b00};

    // Reset with a hazard and forwarding match present: outputs must sit at reset values.
    t = mk(I_ADD_RS1, 1, 5, 8, 8, 8, 1, 8, 1, 0, 0);
    apply(t);
    #1;
    chk("reset_ctl1", 32'(ctl1), 32'(CTL_RUN));
    chk("reset_ctl3", 32'(ctl3), 32'(CTL_RUN));
    chk("reset_fwd_a", 32'(if1.fwd_a), 32'd0);
    chk("reset_fwd_b", 32'(if3.fwd_b), 32'd0);
    apply(neutral);
    #11 rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      apply(tbl[i].in);
      #1;
      chk({tbl[i].name, "_ctl1"}, 32'(ctl1), 32'(tbl[i].ctl));
      chk({tbl[i].name, "_ctl3"}, 32'(ctl3), 32'(tbl[i].ctl));
      chk({tbl[i].name, "_fa"},   32'(if1.fwd_a), 32'(tbl[i].fa));
      chk({tbl[i].name, "_fb"},   32'(if3.fwd_b), 32'(tbl[i].fb));
      #1 apply(neutral);
    end

    // Load-use latency: LAT=1 stalls once, LAT=3 stalls three cycles.
    @(negedge clk); apply(hz); #1;
    chk("lat_c0_d1", 32'(ctl1), 32'(CTL_STALL));
    chk("lat_c0_d3", 32'(ctl3), 32'(CTL_STALL));
    @(negedge clk); apply(bubble); #1;
    chk("lat_c1_d1", 32'(ctl1), 32'(CTL_RUN));
    chk("lat_c1_d3", 32'(ctl3), 32'(CTL_STALL));
    @(negedge clk); #1;
    chk("lat_c2_d3", 32'(ctl3), 32'(CTL_STALL));
    @(negedge clk); #1;
    chk("lat_c3_d3", 32'(ctl3), 32'(CTL_RUN));
    chk("lat_c3_d1", 32'(ctl1), 32'(CTL_RUN));
    apply(neutral);

    // mem_busy for 4 cycles during LSTALL, then the hazard restarts the stall.
    @(negedge clk); apply(hz); #1;
    chk("mw_c0_d3", 32'(ctl3), 32'(CTL_STALL));
    t = hz; t.busy = 1'b1;
    @(negedge clk); apply(t);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      chk($sformatf("mw_freeze_c%0d_d3", c), 32'(ctl3), 32'(CTL_FREEZE));
      chk($sformatf("mw_freeze_c%0d_d1", c), 32'(ctl1), 32'(CTL_FREEZE));
    end
    @(negedge clk); apply(hz); #1;
    chk("mw_restart_d3", 32'(ctl3), 32'(CTL_STALL));
    chk("mw_restart_d1", 32'(ctl1), 32'(CTL_STALL));
    @(negedge clk); apply(bubble); #1;
    chk("mw_c6_d3", 32'(ctl3), 32'(CTL_STALL));
    chk("mw_c6_d1", 32'(ctl1), 32'(CTL_RUN));
    @(negedge clk); #1;
    chk("mw_c7_d3", 32'(ctl3), 32'(CTL_STALL));
    @(negedge clk); #1;
    chk("mw_c8_d3", 32'(ctl3), 32'(CTL_RUN));
    apply(neutral);

    // branch_taken aborts an LSTALL.
    @(negedge clk); apply(hz); #1;
    chk("br_c0_d3", 32'(ctl3), 32'(CTL_STALL));
    t = bubble; t.branch = 1'b1;
    @(negedge clk); apply(t); #1;
    chk("br_abort_d3", 32'(ctl3), 32'(CTL_FLUSH));
    @(negedge clk); apply(neutral); #1;
    chk("br_after_d3", 32'(ctl3), 32'(CTL_RUN));

    // Asynchronous reset mid-LSTALL.
    @(negedge clk); apply(hz); #1;
    chk("rst_c0_d3", 32'(ctl3), 32'(CTL_STALL));
    t = bubble; t.rs1 = 5'd5; t.exmem_rd = 5'd5; t.exmem_rw = 1'b1;
    @(negedge clk); apply(t); #1;
    chk("rst_c1_d3", 32'(ctl3), 32'(CTL_STALL));
    chk("rst_c1_fa", 32'(if3.fwd_a), 32'b10);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_d3", 32'(ctl3), 32'(CTL_RUN));
    chk("rst_async_fa", 32'(if3.fwd_a), 32'd0);
    @(negedge clk); apply(neutral); rst_n = 1'b1; #1;
    chk("rst_release_d3", 32'(ctl3), 32'(CTL_RUN));
    @(negedge clk); #1;
    chk("rst_idle_d3", 32'(ctl3), 32'(CTL_RUN));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Next-generation hazard controller for the 5-stage pipelined RISC core.
- Detects load-use hazards using opcode-aware rs1/rs2 usage decode and stalls IF/ID for a parametrised load latency.
- Flushes on taken branches and freezes the whole pipeline while data memory is busy.
- Generates EX-stage operand forwarding selects.
- Sits between the ID/EX/MEM pipeline registers and the PC / IF-ID / ID-EX write and clear controls.

Parameters:
N, 32, instruction/PC width
REG_W, 5, register address width
LOAD_LAT, 1, stall cycles per load-use hazard (1..7)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_instr  in  N  instruction in IF/ID
idex_memread  in  1  ID/EX holds a load
idex_rd  in  REG_W  ID/EX destination
idex_rs1  in  REG_W  ID/EX source 1 (for forwarding)
idex_rs2  in  REG_W  ID/EX source 2 (for forwarding)
exmem_rd  in  REG_W  EX/MEM destination
exmem_regwrite  in  1  EX/MEM writes the register file
memwb_rd  in  REG_W  MEM/WB destination
memwb_regwrite  in  1  MEM/WB writes the register file
branch_taken  in  1  EX resolved a taken branch or jump
mem_busy  in  1  data memory not ready
pc_write  out  1  1 = PC updates
ifid_write  out  1  1 = IF/ID loads
pipe_hold  out  1  1 = ID/EX, EX/MEM and MEM/WB hold
ctrl_select  out  1  1 = pass decoded control; 0 = inject bubble into ID/EX
ifid_flush  out  1  clear IF/ID
fwd_a  out  2  EX operand A select
fwd_b  out  2  EX operand B select

Behaviour:
- Clock and reset: single clock domain. rst_n is asynchronous, active low.
- Reset values: state=IDLE, counter=0, pc_write=1, ifid_write=1, pipe_hold=0, ctrl_select=1, ifid_flush=0, fwd_a=fwd_b=00.
- rs2 usage decode, from id_instr[6:0]:
  - R, S, B opcodes use rs1 and rs2.
  - I-ALU, LOAD, JALR use rs1 only.
  - LUI, AUIPC, JAL use neither.
- hazard = idex_memread & idex_rd!=0 & ((uses_rs1 & idex_rd==rs1) | (uses_rs2 & idex_rd==rs2)).
- FSM states: IDLE, LSTALL, MWAIT. All outputs are combinational from state and inputs, so stalls act in the same cycle.
- IDLE:
  - If mem_busy: pc_write=0, ifid_write=0, pipe_hold=1. Go to MWAIT.
  - Else if branch_taken: ifid_flush=1, ctrl_select=0. Stay in IDLE.
  - Else if hazard: pc_write=0, ifid_write=0, ctrl_select=0. Load counter with LOAD_LAT-1. If LOAD_LAT>1 go to LSTALL, else stay in IDLE.
- LSTALL:
  - Same outputs as a hazard cycle. Decrement the counter; at 0, return to IDLE.
  - branch_taken aborts the stall: flush as in IDLE, go to IDLE.
  - mem_busy takes priority: go to MWAIT and discard the counter. The load-use check is re-evaluated after MWAIT.
- MWAIT: full freeze, no flush, ctrl_select=1. Stay while mem_busy; the cycle mem_busy falls, go to IDLE.
- Priority: mem_busy > branch_taken > load-use.
- Forwarding, combinational, evaluated independently for each source:
  - 10 if exmem_regwrite & exmem_rd!=0 & exmem_rd==src.
  - Else 01 if memwb_regwrite & memwb_rd!=0 & memwb_rd==src.
  - Else 00.
  - Forwarding selects are valid regardless of FSM state.
- rst_n asserted mid-stall or mid-freeze returns all outputs to reset values immediately.

Optional Feature:
HAZARD_STATS_EN: adds outputs stall_cycles[31:0] and flush_count[31:0].
- stall_cycles counts IDLE-hazard, LSTALL and MWAIT cycles.
- flush_count counts ifid_flush pulses.
- Both counters saturate at all-ones and reset to 0.
- Without the macro, these ports and registers do not exist.

Decomposition:
- hazard_pkg holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - forwarding encodings FWD_RF=00, FWD_WB=01, FWD_MEM=10
  - FSM state enum
- One sub-module, fwd_unit, is instantiated twice (operand A and operand B).

Test Plan:
- LOAD_LAT=1, ID/EX holds lw x5, next instr add x6,x5,x7 → exactly 1 cycle with pc_write=0, ifid_write=0, ctrl_select=0, then normal flow.
- LOAD_LAT=3, same pair → 3 consecutive stall cycles. If instead ID holds lui x5, or addi x6,x9,x5 encoded with rs2 field=5 (I-type), → no stall.
- idex_rd=0 load with consumer rs1=x0 → no stall. exmem_rd=memwb_rd=x8, both regwrite, idex_rs1=x8 → fwd_a=10. If exmem_regwrite=0 → fwd_a=01.
- mem_busy high for 4 cycles during an LSTALL → pipe_hold=1 for 4 cycles, then IDLE. A hazard still present afterwards restarts the stall.
- branch_taken together with a hazard → ifid_flush=1, ctrl_select=0, pc_write=1, no stall. rst_n pulsed low mid-LSTALL → outputs at reset values asynchronously.
